// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the instruction prefetch buffer.
//   state_t        prefetch FSM state encoding (IDLE/REQ/WAIT/DRAIN)
//   DEPTH_DEFAULT  default queue depth
//   RESET_PC_DEFAULT default first fetch address
//   fetch_entry_t  64-bit queue entry {pc, inst}
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/pipe_fetch_fifo.sv
// pipe_fetch_fifo: DEPTH-entry register FIFO of fetch entries.
//   clock, resetn  clock / asynchronous active-low reset
//   push, push_data  write an entry at the tail
//   pop            advance the head
//   flush          empty the queue (wins over push and pop)
//   count          number of valid entries
//   head           entry at the head, straight from the storage registers
module pipe_fetch_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pipe_prefetch.sv
// pipe_prefetch: instruction prefetch buffer ahead of the IF stage.
// Issues sequential word fetches (one outstanding) over req/gnt/rvalid and
// queues {pc, inst} pairs; redirect flushes the queue and any in-flight reply.
//   clock, resetn           clock / asynchronous active-low reset
//   redirect, redirect_pc   taken control transfer and its target
//   if_req                  IF stage takes the head this cycle
//   if_valid, if_pc, if_inst  queue head
//   mem_req, mem_addr, mem_gnt, mem_rvalid, mem_rdata  memory handshake
// Optional macro PREFETCH_BYPASS_EN: forward a reply straight to IF when the
// queue is empty and IF is requesting.
module pipe_prefetch
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_req,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH-1);

  state_t        state, state_next;
  logic          run;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          gnt_ok, resp, push, pop, bypass, fifo_empty;

  // run holds mem_req low for the first cycle after reset release even
  // though the FSM already sits in REQ.
  assign mem_req    = run & (state == REQ);
  assign gnt_ok     = mem_req & mem_gnt;
  assign mem_addr   = fetch_pc;
  assign resp       = (state == WAIT) & mem_rvalid & ~redirect;
  assign fifo_empty = (count == '0);
  assign pop        = if_req & ~fifo_empty;
  assign push_data  = '{pc: req_pc, inst: mem_rdata};

`ifdef PREFETCH_BYPASS_EN
  assign bypass   = resp & if_req & fifo_empty;
  assign if_valid = ~fifo_empty | bypass;
  assign if_pc    = bypass ? req_pc    : head.pc;
  assign if_inst  = bypass ? mem_rdata : head.inst;
`else
  assign bypass   = 1'b0;
  assign if_valid = ~fifo_empty;
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;
`endif

  assign push = resp & ~bypass;

  always_comb begin
    state_next = state;
    case (state)
      // A pop this cycle frees a slot, so the request can go out next cycle.
      IDLE:  if (redirect || count != FULL || pop) state_next = REQ;
      REQ:   if (gnt_ok) state_next = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (redirect)        state_next = mem_rvalid ? REQ : DRAIN;
        else if (mem_rvalid) state_next = (push && !pop && count == ALMOST) ? IDLE : REQ;
      end
      DRAIN: if (mem_rvalid) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= REQ;
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_next;
      run   <= 1'b1;
      if (redirect)    fetch_pc <= redirect_pc;
      else if (gnt_ok) fetch_pc <= fetch_pc + 32'd4;
      if (gnt_ok) req_pc <= fetch_pc;
    end
  end

  pipe_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_pipe_prefetch.sv
// tb_pipe_prefetch: directed self-checking bench for pipe_prefetch.
// A behavioural memory answers requests with inst = addr ^ 32'hA5A5_A5A5;
// gnt_en and rv_delay shape its grant and response timing.
module tb_pipe_prefetch;

  localparam logic [31:0] K = 32'hA5A5_A5A5;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_req = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bit          gnt_en = 1'b1;
  int          rv_delay = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  pipe_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_req      (if_req),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: grants in the request cycle when enabled, replies
  // rv_delay cycles after the cycle following the grant.
  initial begin
    forever begin
      @(posedge clock);
      if (!resetn) begin
        pend = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        if (mem_gnt && mem_req) begin
          pend = 1'b1; pend_cnt = rv_delay; pend_addr = mem_addr;
        end
        #1;
        mem_rvalid = 1'b0;
        if (pend) begin
          if (pend_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = pend_addr ^ K; pend = 1'b0;
          end else pend_cnt--;
        end
        mem_gnt = gnt_en && mem_req;
      end
    end
  end

  // Leaves the caller at the negedge where resetn was released.
  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; if_req = 1'b0; redirect = 1'b0; gnt_en = 1'b1; rv_delay = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_release_req: got %b want 0", mem_req); end
    @(negedge clock);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] got_pc [8];
    logic [31:0] got_inst [8];
    int          got_cyc [8];
    int          n_got = 0;
    logic        exp_v;
    do_reset();
    if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);  // request cycle
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req k=%0d: got %b want 1", k, mem_req); end
      n_cmp++; if (mem_addr !== 32'(4*k)) begin n_bad++; $display("FAIL stream_addr k=%0d: got %h want %h", k, mem_addr, 32'(4*k)); end
      exp_v = !BYP && (k > 0);
      n_cmp++; if (if_valid !== exp_v) begin n_bad++; $display("FAIL stream_valid_req k=%0d: got %b want %b", k, if_valid, exp_v); end
      if (if_valid && if_req && n_got < 8) begin got_pc[n_got] = if_pc; got_inst[n_got] = if_inst; got_cyc[n_got] = 2*k; n_got++; end
      @(negedge clock);  // response cycle
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL stream_noreq k=%0d: got %b want 0", k, mem_req); end
      exp_v = BYP;
      n_cmp++; if (if_valid !== exp_v) begin n_bad++; $display("FAIL stream_valid_resp k=%0d: got %b want %b", k, if_valid, exp_v); end
      if (if_valid && if_req && n_got < 8) begin got_pc[n_got] = if_pc; got_inst[n_got] = if_inst; got_cyc[n_got] = 2*k+1; n_got++; end
    end
    if_req = 1'b0;
    n_cmp++; if (n_got !== (BYP ? 4 : 3)) begin n_bad++; $display("FAIL stream_count: got %0d want %0d", n_got, BYP ? 4 : 3); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got_pc[i] !== 32'(4*i)) begin n_bad++; $display("FAIL stream_pc i=%0d: got %h want %h", i, got_pc[i], 32'(4*i)); end
      n_cmp++; if (got_inst[i] !== (32'(4*i) ^ K)) begin n_bad++; $display("FAIL stream_inst i=%0d: got %h want %h", i, got_inst[i], 32'(4*i) ^ K); end
      if (i > 0) begin
        n_cmp++; if (got_cyc[i] - got_cyc[i-1] !== 2) begin n_bad++; $display("FAIL stream_spacing i=%0d: got %0d want 2", i, got_cyc[i] - got_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] addrs [8];
    int          n_f = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_req && mem_gnt && n_f < 8) begin addrs[n_f] = mem_addr; n_f++; end
    end
    n_cmp++; if (n_f !== 4) begin n_bad++; $display("FAIL full_fetches: got %0d want 4", n_f); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addrs[i] !== 32'(4*i)) begin n_bad++; $display("FAIL full_addr i=%0d: got %h want %h", i, addrs[i], 32'(4*i)); end
    end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL full_req_low: got %b want 0", mem_req); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL full_head_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_inst !== K) begin n_bad++; $display("FAIL full_head_inst: got %h want %h", if_inst, K); end
    if_req = 1'b1;
    @(negedge clock);
    if_req = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL full_refetch_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL full_refetch_addr: got %h want 10", mem_addr); end
    n_cmp++; if (if_pc !== 32'h4) begin n_bad++; $display("FAIL full_next_head: got %h want 4", if_pc); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rv_delay = 3;
    @(negedge clock);  // c1: request granted
    @(negedge clock);  // c2: waiting
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdw_wait_req: got %b want 0", mem_req); end
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clock);  // c3
    redirect = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdw_drain_req: got %b want 0", mem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_flush_valid: got %b want 0", if_valid); end
    @(negedge clock);  // c4
    @(negedge clock);  // c5: stale reply arrives
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdw_stale_req: got %b want 0", mem_req); end
    rv_delay = 0;
    @(negedge clock);  // c6
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rdw_new_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h400) begin n_bad++; $display("FAIL rdw_new_addr: got %h want 400", mem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_discarded: got %b want 0", if_valid); end
    repeat (2) @(negedge clock);  // c8
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h400) begin n_bad++; $display("FAIL rdw_pc: got %h want 400", if_pc); end
    n_cmp++; if (if_inst !== (32'h400 ^ K)) begin n_bad++; $display("FAIL rdw_inst: got %h want %h", if_inst, 32'h400 ^ K); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    @(negedge clock);  // c1
    @(negedge clock);  // c2: reply present
    redirect = 1'b1; redirect_pc = 32'h800;
    @(negedge clock);  // c3
    redirect = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rdr_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h800) begin n_bad++; $display("FAIL rdr_addr: got %h want 800", mem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rdr_dropped: got %b want 0", if_valid); end
    repeat (2) @(negedge clock);  // c5
    n_cmp++; if (if_pc !== 32'h800) begin n_bad++; $display("FAIL rdr_pc: got %h want 800", if_pc); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rdr_valid: got %b want 1", if_valid); end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    rv_delay = 1;
    @(negedge clock);  // c1: grant this cycle
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clock);  // c2
    redirect = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdg_drain_c2: got %b want 0", mem_req); end
    @(negedge clock);  // c3: stale reply
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdg_drain_c3: got %b want 0", mem_req); end
    @(negedge clock);  // c4
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rdg_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL rdg_addr: got %h want 200", mem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rdg_valid: got %b want 0", if_valid); end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    gnt_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL stall_req c=%0d: got %b want 1", c, mem_req); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL stall_addr c=%0d: got %h want 0", c, mem_addr); end
    end
    redirect = 1'b1; redirect_pc = 32'h120;
    @(negedge clock);  // c4
    redirect = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL stall_redir_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h120) begin n_bad++; $display("FAIL stall_redir_addr: got %h want 120", mem_addr); end
    @(negedge clock);  // c5
    n_cmp++; if (mem_addr !== 32'h120) begin n_bad++; $display("FAIL stall_hold_addr: got %h want 120", mem_addr); end
    gnt_en = 1'b1;
    repeat (3) @(negedge clock);  // c8
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h120) begin n_bad++; $display("FAIL stall_pc: got %h want 120", if_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clock);  // c1
    redirect = 1'b0;
    n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got %h want fffffffc", mem_addr); end
    repeat (2) @(negedge clock);  // c3
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", mem_addr); end
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc); end
  endtask

  task automatic test_bypass();
    do_reset();
    if_req = 1'b1;
    @(negedge clock);  // c1
    @(negedge clock);  // c2: reply cycle
`ifdef PREFETCH_BYPASS_EN
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_inst !== K) begin n_bad++; $display("FAIL byp_inst: got %h want %h", if_inst, K); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL byp_pc: got %h want 0", if_pc); end
    @(negedge clock);  // c3: consumed, nothing queued
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL byp_after: got %b want 0", if_valid); end
`else
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL nobyp_valid: got %b want 0", if_valid); end
    @(negedge clock);  // c3
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL nobyp_late_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_inst !== K) begin n_bad++; $display("FAIL nobyp_inst: got %h want %h", if_inst, K); end
`endif
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_gnt();
    test_gnt_stall();
    test_wrap();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
